// File: rtl/hamming_decoder_rx_pkg.sv
// rtl/hamming_decoder_rx_pkg.sv - shared Hamming(7,4) codeword positions, widths and decoder states
package hamming_decoder_rx_pkg;

  // Codeword and message widths
  localparam int CW_W  = 7;
  localparam int MSG_W = 4;

  // 1-based positions in code[1:7] = {p1,p2,d1,p3,d2,d3,d4}; the encoder uses the same map
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int D1 = 3;
  localparam int P3 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;
  localparam int D4 = 7;

  typedef enum logic [1:0] {
    SHIFT  = 2'd0,
    DECODE = 2'd1,
    OUT    = 2'd2
  } state_t;

endpackage

// File: rtl/hamming_syndrome_fix.sv
// rtl/hamming_syndrome_fix.sv - combinational syndrome, single-bit correction and data extraction
module hamming_syndrome_fix
  import hamming_decoder_rx_pkg::*;
(
  input  logic [1:CW_W]  code,
  output logic [2:0]     syndrome,
  output logic [1:CW_W]  fixed,
  output logic [1:MSG_W] msg
);

  // Syndrome bits are parity checks over the positions whose index has that bit set
  always_comb begin
    syndrome[0] = code[P1] ^ code[D1] ^ code[D2] ^ code[D4];
    syndrome[1] = code[P2] ^ code[D1] ^ code[D3] ^ code[D4];
    syndrome[2] = code[P3] ^ code[D2] ^ code[D3] ^ code[D4];
  end

  // Flip the bit the syndrome points at; syndrome 0 matches no position so the word passes through
  always_comb begin
    fixed = code;
    for (int i = 1; i <= CW_W; i++) begin
      fixed[i] = code[i] ^ (syndrome == 3'(i));
    end
  end

  // Data bits come from the corrected word, so a parity-position hit leaves msg untouched
  always_comb begin
    msg = {fixed[D1], fixed[D2], fixed[D3], fixed[D4]};
  end

endmodule

// File: rtl/hamming_decoder_rx.sv
// rtl/hamming_decoder_rx.sv - serial Hamming(7,4) receiver with correction; HAMMING_ERR_CNT_EN adds err_cnt
module hamming_decoder_rx
  import hamming_decoder_rx_pkg::*;
#(
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:MSG_W]   msg,
  output logic [2:0]       syndrome,
  output logic             corrected,
  output logic             out_valid,
  input  logic             out_ready
`ifdef HAMMING_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  state_t              state_q;
  state_t              state_d;
  logic [2:0]          bit_cnt;
  logic [1:CW_W]       code_q;
  logic [2:0]          slot;
  logic                accept;
  logic [2:0]          fix_syndrome;
  logic [1:CW_W]       fix_code;
  logic [1:MSG_W]      fix_msg;

  hamming_syndrome_fix u_fix (
    .code     (code_q),
    .syndrome (fix_syndrome),
    .fixed    (fix_code),
    .msg      (fix_msg)
  );

  assign accept = in_valid && in_ready;
  assign slot   = (MSB_FIRST != 0) ? (bit_cnt + 3'd1) : (3'd7 - bit_cnt);

  // Next state and handshake outputs; OUT never bypasses straight back into a new bit
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      SHIFT: begin
        in_ready = 1'b1;
        if (in_valid && (bit_cnt == 3'd6)) state_d = DECODE;
      end
      DECODE: begin
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = SHIFT;
      end
      default: begin
        state_d = SHIFT;
      end
    endcase
  end

  // State, bit counter and shift register; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHIFT;
      bit_cnt <= 3'd0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        code_q[slot] <= in_bit;
        bit_cnt      <= (bit_cnt == 3'd6) ? 3'd0 : (bit_cnt + 3'd1);
      end
    end
  end

  // Result registers load once in DECODE and hold through OUT
  always_ff @(posedge clk) begin
    if (rst) begin
      msg       <= '0;
      syndrome  <= 3'd0;
      corrected <= 1'b0;
    end else if (state_q == DECODE) begin
      msg       <= fix_msg;
      syndrome  <= fix_syndrome;
      corrected <= (fix_syndrome != 3'd0);
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  // Saturating count of decoded words that needed a correction
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((state_q == DECODE) && (fix_syndrome != 3'd0) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
